reg_dump: RTL and testbench
===========================

Name: reg_dump

Overview:
- Debug read-out engine for the OTTER register file.
- On request, walks addresses x0..x31 through a spare combinational read port of REG_FILE and streams the contents out as 32-bit words over a valid/ready interface, typically into the debug UART bridge.
- Stream format: a header word, the 32 register values, then an XOR checksum (34 words total).
- Used while the CPU is halted; the block takes no snapshot and does not stall writeback.

Parameters:
- NUM_REGS, 32: registers streamed. Must equal 2**ADDR_W.
- ADDR_W, 5: register address width.
- DATA_W, 32: register and stream word width.
- HEADER, 32'hD00D_0001: constant first word of every dump.

Ports:
- DMP_CLK  input  1  system clock; all state on rising edge.
- DMP_RST_N  input  1  reset, asynchronous, active-low.
- DMP_START  input  1  dump request; sampled only in IDLE.
- DMP_ABORT  input  1  synchronous abort of a dump in progress.
- DMP_RF_ADR  output  ADDR_W  address to register-file read port (combinational read, data valid same cycle).
- DMP_RF_DATA  input  DATA_W  register-file read data for DMP_RF_ADR.
- DMP_TX_DATA  output  DATA_W  stream word.
- DMP_TX_VALID  output  1  stream word valid.
- DMP_TX_READY  input  1  downstream accepts word.
- DMP_BUSY  output  1  high from the cycle after START acceptance until return to IDLE.
- DMP_DONE  output  1  one-cycle pulse after the checksum word is accepted.

Behaviour:
- Clock and reset: one clock, DMP_CLK. Reset DMP_RST_N is asynchronous, active-low.
- Reset values: state IDLE, idx=0, csum=0, DMP_RF_ADR=0, DMP_TX_DATA=0, DMP_TX_VALID=0, DMP_BUSY=0, DMP_DONE=0.
- Reset assertion clears everything immediately, not at the next edge, including mid-dump. DMP_TX_VALID drops without a handshake.
- Beat: a word transfers on a rising edge where DMP_TX_VALID=1 and DMP_TX_READY=1.
- Hold rule: while DMP_TX_VALID=1 and DMP_TX_READY=0, DMP_TX_DATA holds stable. DMP_TX_VALID never deasserts without a beat, except on abort or reset.
- All outputs are registered. DMP_RF_ADR is driven directly from idx.
- IDLE:
  - DMP_START=1 at an edge loads DMP_TX_DATA=HEADER, sets DMP_TX_VALID=1 and DMP_BUSY=1, clears idx and csum, and enters HDR.
  - Latency is one cycle from START to the header being valid.
- HDR:
  - On a beat: DMP_TX_DATA<=DMP_RF_DATA (reg at idx=0), csum<=csum^DMP_RF_DATA, idx<=1, enter REGS.
- REGS:
  - Register value for index k is sampled from DMP_RF_DATA at the edge where word k-1 (or the header) is accepted.
  - On a beat with idx<NUM_REGS: load DMP_RF_DATA, fold it into csum, idx<=idx+1.
  - On a beat with idx==NUM_REGS: load DMP_TX_DATA<=csum, enter CSUM.
  - idx is ADDR_W+1 bits internally. DMP_RF_ADR = idx[ADDR_W-1:0], which wraps to 0 at idx=32 (don't-care read).
- CSUM:
  - On a beat: DMP_TX_VALID<=0, DMP_BUSY<=0, DMP_DONE<=1 for exactly one cycle, enter IDLE.
- Throughput: with DMP_TX_READY held high, one word per cycle; 34 beats take 34 consecutive cycles.
- x0 is streamed as read (expected 0). Checksum covers x0..x31 only, not HEADER.
- DMP_START while BUSY: ignored, no queueing. START in the same cycle as the DONE pulse: accepted, since state is IDLE at that edge.
- DMP_ABORT:
  - In any non-IDLE state at an edge: return to IDLE, DMP_TX_VALID=0, DMP_BUSY=0, no DONE pulse, idx and csum cleared. ABORT has priority over a coincident beat.
  - ABORT in IDLE: no effect, and also suppresses a same-cycle START.
- Register writes to REG_FILE during a dump are not prevented; the streamed value is whatever is read at the sampling edge.

Test Plan:
- Preload x1=32'h1111_1111, x2=32'h0000_00FF, all others 0; pulse START with READY=1 -> VALID high next cycle; words in order D00D0001, 0, 11111111, 000000FF, 0 (x29 more), checksum 111111EE; DONE pulse one cycle after the 34th beat; BUSY high exactly 34 cycles.
- Same preload, READY toggling 1,0,0,1,... -> identical 34-word sequence; DMP_TX_DATA stable during every READY=0 cycle; no word dropped or duplicated.
- Assert ABORT after 5 beats -> VALID and BUSY low next cycle; no DONE; new START yields a fresh sequence beginning D00D0001 with checksum unchanged from the full run.
- Drop DMP_RST_N asynchronously mid-dump, between clock edges -> VALID, BUSY, TX_DATA, RF_ADR read 0 before the next edge; after release, the block sits in IDLE until START.
- Pulse START repeatedly while BUSY -> exactly one 34-word dump; START in the DONE cycle -> second dump starts, header valid next cycle.
- x31=32'hFFFF_FFFF, others 0 -> word 33 is FFFFFFFF, checksum FFFFFFFF; confirms DMP_RF_ADR reaches 31 and idx terminates without wrap artefacts.

Source files
------------

// File: rtl/reg_dump_if.sv
// reg_dump_if: start/abort control, register-file read port and word stream of the dump engine.
interface reg_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              DMP_START;
  logic              DMP_ABORT;
  logic [ADDR_W-1:0] DMP_RF_ADR;
  logic [DATA_W-1:0] DMP_RF_DATA;
  logic [DATA_W-1:0] DMP_TX_DATA;
  logic              DMP_TX_VALID;
  logic              DMP_TX_READY;
  logic              DMP_BUSY;
  logic              DMP_DONE;
  modport master (
    input  DMP_START, DMP_ABORT, DMP_RF_DATA, DMP_TX_READY,
    output DMP_RF_ADR, DMP_TX_DATA, DMP_TX_VALID, DMP_BUSY, DMP_DONE
  );
  modport slave (
    output DMP_START, DMP_ABORT, DMP_RF_DATA, DMP_TX_READY,
    input  DMP_RF_ADR, DMP_TX_DATA, DMP_TX_VALID, DMP_BUSY, DMP_DONE
  );
endinterface

// File: rtl/reg_dump.sv
// reg_dump: streams header, x0..x31 and their XOR checksum over valid/ready.
module reg_dump #(
  parameter int              NUM_REGS = 32,
  parameter int              ADDR_W   = 5,
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] HEADER = 32'hD00D_0001
) (
  input logic DMP_CLK,
  input logic DMP_RST_N,
  reg_dump_if.master dmp
);
  typedef enum logic [1:0] {IDLE, HDR, REGS, CSUM} state_t;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS);
  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              beat;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    beat    = valid_q && dmp.DMP_TX_READY;
    // abort wins over any coincident beat and, in IDLE, swallows a start
    if (dmp.DMP_ABORT) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        idx_d   = '0;
        csum_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: if (dmp.DMP_START) begin
          state_d = HDR;
          idx_d   = '0;
          csum_d  = '0;
          data_d  = HEADER;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
        HDR, REGS: if (beat) begin
          if (idx_q < LAST_IDX) begin
            data_d  = dmp.DMP_RF_DATA;
            csum_d  = csum_q ^ dmp.DMP_RF_DATA;
            idx_d   = idx_q + (ADDR_W+1)'(1);
            state_d = REGS;
          end else begin
            data_d  = csum_q;
            state_d = CSUM;
          end
        end
        CSUM: if (beat) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge DMP_CLK or negedge DMP_RST_N) begin
    if (!DMP_RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign dmp.DMP_RF_ADR   = idx_q[ADDR_W-1:0];
  assign dmp.DMP_TX_DATA  = data_q;
  assign dmp.DMP_TX_VALID = valid_q;
  assign dmp.DMP_BUSY     = busy_q;
  assign dmp.DMP_DONE     = done_q;
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: drives dumps against a register-file array and checks streams against a list model.
module tb_reg_dump;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  reg_dump_if dif ();
  reg_dump dut (.DMP_CLK(clk), .DMP_RST_N(rst_n), .dmp(dif));
  logic [31:0] rf [32];
  assign dif.DMP_RF_DATA = rf[dif.DMP_RF_ADR];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] got [$];
  logic [31:0] exp_q [$];
  int hold_bad, busy_n, done_cyc, last_beat, timed_out;

  task automatic build_exp();
    logic [31:0] c = '0;
    exp_q.delete();
    exp_q.push_back(32'hD00D_0001);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(rf[i]);
      c ^= rf[i];
    end
    exp_q.push_back(c);
  endtask

  task automatic preload_spec();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'h1111_1111;
    rf[2] = 32'h0000_00FF;
  endtask

  task automatic start_dump();
    dif.DMP_START = 1'b1;
    @(negedge clk);
    dif.DMP_START = 1'b0;
  endtask

  // records accepted words; mode 0 ready high, 1 pattern 1,0,0,1, 2 random
  task automatic collect(input int mode, input bit spam_start);
    logic pv = 1'b0, pr = 1'b0, r;
    logic [31:0] pd = '0;
    got.delete();
    hold_bad = 0; busy_n = 0; done_cyc = -1; last_beat = -1; timed_out = 1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (dif.DMP_BUSY) busy_n++;
      if (pv && !pr && (!dif.DMP_TX_VALID || dif.DMP_TX_DATA !== pd)) hold_bad++;
      if (dif.DMP_DONE) begin
        done_cyc = cyc;
        timed_out = 0;
        break;
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (cyc % 4 == 0) || (cyc % 4 == 3);
      else r = 1'($urandom_range(0, 1));
      dif.DMP_TX_READY = r;
      dif.DMP_START = spam_start && (cyc % 3 == 1);
      if (dif.DMP_TX_VALID && r) begin
        got.push_back(dif.DMP_TX_DATA);
        last_beat = cyc;
      end
      pv = dif.DMP_TX_VALID; pr = r; pd = dif.DMP_TX_DATA;
      @(negedge clk);
    end
    dif.DMP_START = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dif.DMP_TX_VALID, dif.DMP_BUSY, dif.DMP_DONE, dif.DMP_TX_DATA, dif.DMP_RF_ADR} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b data=%h adr=%0d required all 0",
               dif.DMP_TX_VALID, dif.DMP_BUSY, dif.DMP_DONE, dif.DMP_TX_DATA, dif.DMP_RF_ADR);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dif.DMP_BUSY !== 1'b0 || dif.DMP_TX_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b valid=%b required 0 0", dif.DMP_BUSY, dif.DMP_TX_VALID);
    end
  endtask

  task automatic test_basic();
    preload_spec();
    build_exp();
    start_dump();
    n_cmp++;
    if (dif.DMP_TX_VALID !== 1'b1 || dif.DMP_TX_DATA !== 32'hD00D_0001) begin
      n_bad++;
      $display("FAIL basic_header: valid=%b data=%h required 1 d00d0001", dif.DMP_TX_VALID, dif.DMP_TX_DATA);
    end
    collect(0, 1'b0);
    n_cmp++;
    if (timed_out != 0) begin n_bad++; $display("FAIL basic_timeout: no DONE within bound"); end
    n_cmp++;
    if (got.size() != 34) begin
      n_bad++;
      $display("FAIL basic_len: got %0d words required 34", got.size());
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL basic_word[%0d]: got %h required %h", i, got[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (got[33] !== 32'h1111_11EE) begin
        n_bad++;
        $display("FAIL basic_csum: got %h required 111111ee", got[33]);
      end
    end
    n_cmp++;
    if (last_beat != 33) begin n_bad++; $display("FAIL basic_throughput: last beat cycle %0d required 33", last_beat); end
    n_cmp++;
    if (busy_n != 34) begin n_bad++; $display("FAIL basic_busy: busy cycles %0d required 34", busy_n); end
    n_cmp++;
    if (done_cyc != last_beat + 1) begin n_bad++; $display("FAIL basic_done_lag: done at %0d required %0d", done_cyc, last_beat + 1); end
    @(negedge clk);
    n_cmp++;
    if (dif.DMP_DONE !== 1'b0 || dif.DMP_TX_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: done=%b valid=%b required 0 0", dif.DMP_DONE, dif.DMP_TX_VALID);
    end
  endtask

  task automatic test_backpressure();
    preload_spec();
    build_exp();
    start_dump();
    collect(1, 1'b0);
    n_cmp++;
    if (hold_bad != 0 || timed_out != 0) begin
      n_bad++;
      $display("FAIL bp_hold: hold violations %0d timeout %0d required 0 0", hold_bad, timed_out);
    end
    n_cmp++;
    if (got.size() != 34) begin
      n_bad++;
      $display("FAIL bp_len: got %0d words required 34", got.size());
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_word[%0d]: got %h required %h", i, got[i], exp_q[i]); end
      end
    end
    n_cmp++;
    if (busy_n != last_beat + 1) begin n_bad++; $display("FAIL bp_busy: busy cycles %0d required %0d", busy_n, last_beat + 1); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int dn = 0;
    preload_spec();
    build_exp();
    start_dump();
    dif.DMP_TX_READY = 1'b1;
    repeat (5) @(negedge clk);
    dif.DMP_ABORT = 1'b1;
    @(negedge clk);
    dif.DMP_ABORT = 1'b0;
    n_cmp++;
    if (dif.DMP_TX_VALID !== 1'b0 || dif.DMP_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_stop: valid=%b busy=%b required 0 0", dif.DMP_TX_VALID, dif.DMP_BUSY);
    end
    for (int i = 0; i < 4; i++) begin
      if (dif.DMP_DONE) dn++;
      @(negedge clk);
    end
    n_cmp++;
    if (dn != 0) begin n_bad++; $display("FAIL abort_no_done: done pulses %0d required 0", dn); end
    dif.DMP_ABORT = 1'b1;
    dif.DMP_START = 1'b1;
    @(negedge clk);
    dif.DMP_ABORT = 1'b0;
    dif.DMP_START = 1'b0;
    n_cmp++;
    if (dif.DMP_BUSY !== 1'b0 || dif.DMP_TX_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle_start: busy=%b valid=%b required 0 0", dif.DMP_BUSY, dif.DMP_TX_VALID);
    end
    start_dump();
    collect(0, 1'b0);
    n_cmp++;
    if (got.size() != 34) begin
      n_bad++;
      $display("FAIL abort_restart_len: got %0d words required 34", got.size());
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL abort_restart_word[%0d]: got %h required %h", i, got[i], exp_q[i]); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    preload_spec();
    rf[7] = 32'hCAFE_F00D;
    start_dump();
    dif.DMP_TX_READY = 1'b1;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dif.DMP_TX_VALID, dif.DMP_BUSY, dif.DMP_TX_DATA, dif.DMP_RF_ADR} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: valid=%b busy=%b data=%h adr=%0d required all 0",
               dif.DMP_TX_VALID, dif.DMP_BUSY, dif.DMP_TX_DATA, dif.DMP_RF_ADR);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (dif.DMP_BUSY !== 1'b0 || dif.DMP_TX_VALID !== 1'b0 || dif.DMP_DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_idle: busy=%b valid=%b done=%b required 0 0 0", dif.DMP_BUSY, dif.DMP_TX_VALID, dif.DMP_DONE);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    build_exp();
    start_dump();
    collect(0, 1'b1);
    n_cmp++;
    if (got.size() != 34 || timed_out != 0) begin
      n_bad++;
      $display("FAIL b2b_single: got %0d words timeout %0d required 34 0", got.size(), timed_out);
    end
    dif.DMP_START = 1'b1;
    @(negedge clk);
    dif.DMP_START = 1'b0;
    n_cmp++;
    if (dif.DMP_TX_VALID !== 1'b1 || dif.DMP_TX_DATA !== 32'hD00D_0001) begin
      n_bad++;
      $display("FAIL b2b_done_start: valid=%b data=%h required 1 d00d0001", dif.DMP_TX_VALID, dif.DMP_TX_DATA);
    end
    collect(0, 1'b0);
    n_cmp++;
    if (got.size() != 34) begin
      n_bad++;
      $display("FAIL b2b_len: got %0d words required 34", got.size());
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_word[%0d]: got %h required %h", i, got[i], exp_q[i]); end
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dif.DMP_TX_VALID !== 1'b0 || dif.DMP_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_no_queue: valid=%b busy=%b required 0 0", dif.DMP_TX_VALID, dif.DMP_BUSY);
    end
  endtask

  task automatic test_x31();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[31] = 32'hFFFF_FFFF;
    start_dump();
    collect(2, 1'b0);
    n_cmp++;
    if (got.size() != 34) begin
      n_bad++;
      $display("FAIL x31_len: got %0d words required 34", got.size());
    end else begin
      n_cmp++;
      if (got[32] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL x31_word: got %h required ffffffff", got[32]); end
      n_cmp++;
      if (got[33] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL x31_csum: got %h required ffffffff", got[33]); end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      build_exp();
      start_dump();
      collect(2, 1'b0);
      n_cmp++;
      if (hold_bad != 0 || timed_out != 0 || got.size() != 34) begin
        n_bad++;
        $display("FAIL rand_run%0d: holds %0d timeout %0d words %0d required 0 0 34", t, hold_bad, timed_out, got.size());
      end else begin
        for (int i = 0; i < 34; i++) begin
          n_cmp++;
          if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_word%0d[%0d]: got %h required %h", t, i, got[i], exp_q[i]); end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dif.DMP_START = 1'b0;
    dif.DMP_ABORT = 1'b0;
    dif.DMP_TX_READY = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_x31();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
